uart_tx: RTL and testbench

Serial UART transmitter, the send-side counterpart of the UART receiver in the same link. It shares the receiver's 16x oversampling `s_tick` from the baud generator and frames bytes LSB-first as: start bit, DBIT data bits, optional parity bit, stop period. A one-entry holding register with a valid/ready handshake lets the game logic queue the next byte while the current one shifts, so consecutive frames go out back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_hold.sv | 27 ++
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and framing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a. The PARITY state is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE    = 16;
    localparam int UART_MAX_DBIT = 8;
    localparam int UART_S_W      = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register in front of the transmit shifter.
// Latency: byte captured on the wr edge; full flag visible the cycle after.
// Backpressure: full stays set until the FSM pulls the byte with rd.
module uart_tx_hold (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full
);

    // Capture on write, release on read; wr only fires when empty and rd only when full
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            dout <= 8'h00;
        end else if (wr) begin
            full <= 1'b1;
            dout <= din;
        end else if (rd) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DBIT data bits LSB-first, optional even parity, stop period.
// Latency: line drops to the start bit one clk after a byte is accepted while idle.
// Backpressure: tx_ready low while the one-entry holding register is full.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit before the stop period.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic [7:0] din,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);

    localparam logic [UART_S_W-1:0] S_BIT_LAST  = UART_S_W'(OVERSAMPLE - 1);
    localparam logic [UART_S_W-1:0] S_STOP_LAST = UART_S_W'(SB_TICK - 1);
    localparam logic [2:0]          N_LAST      = 3'(DBIT - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic [7:0]          DMASK       = 8'((1 << DBIT) - 1);
`endif

    uart_tx_state_t             state_q;
    logic [UART_S_W-1:0]        s_q;
    logic [2:0]                 n_q;
    logic [UART_MAX_DBIT-1:0]   b_q;
    logic                       tx_q;
    logic                       done_q;
`ifdef UART_TX_PARITY_EN
    logic                       par_q;
`endif

    logic       hold_full;
    logic [7:0] hold_dat;
    logic       hold_wr;
    logic       hold_rd;
    logic       stop_end;

    // The final stop tick is also the load point for a queued byte, giving gapless frames
    assign stop_end = (state_q == ST_STOP) && s_tick && (s_q == S_STOP_LAST);
    assign hold_wr  = tx_valid && !hold_full;
    assign hold_rd  = hold_full && ((state_q == ST_IDLE) || stop_end);

    assign tx_ready     = !hold_full;
    assign tx           = tx_q;
    assign tx_busy      = (state_q != ST_IDLE);
    assign tx_done_tick = done_q;

    uart_tx_hold u_hold (
        .clk   (clk),
        .reset (reset),
        .wr    (hold_wr),
        .rd    (hold_rd),
        .din   (din),
        .dout  (hold_dat),
        .full  (hold_full)
    );

    // Frame sequencer: tick/bit counting, shifting and the registered serial line
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hold_full) begin
                        b_q     <= hold_dat;
                        s_q     <= '0;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^(hold_dat & DMASK);
`endif
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (s_q == S_BIT_LAST) begin
                            s_q     <= '0;
                            n_q     <= '0;
                            tx_q    <= b_q[0];
                            state_q <= ST_DATA;
                        end else begin
                            s_q <= s_q + UART_S_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (s_q == S_BIT_LAST) begin
                            s_q <= '0;
                            b_q <= {1'b0, b_q[UART_MAX_DBIT-1:1]};
                            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                                tx_q    <= par_q;
                                state_q <= ST_PARITY;
`else
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
`endif
                            end else begin
                                n_q  <= n_q + 3'd1;
                                tx_q <= b_q[1];
                            end
                        end else begin
                            s_q <= s_q + UART_S_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (s_tick) begin
                        if (s_q == S_BIT_LAST) begin
                            s_q     <= '0;
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            s_q <= s_q + UART_S_W'(1);
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (s_tick) begin
                        if (s_q == S_STOP_LAST) begin
                            done_q <= 1'b1;
                            s_q    <= '0;
                            if (hold_full) begin
                                b_q     <= hold_dat;
                                tx_q    <= 1'b0;
                                state_q <= ST_START;
`ifdef UART_TX_PARITY_EN
                                par_q   <= ^(hold_dat & DMASK);
`endif
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            s_q <= s_q + UART_S_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a default instance (DBIT=8, SB_TICK=16) and a
// DBIT=7, SB_TICK=32 instance share clock, reset and s_tick. Expected frames are
// hand-written bit strings in line order; parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       cont_tick;
    logic [1:0] div = 2'd0;
    logic       s_tick;

    logic [7:0] din0, din1;
    logic       val0, val1;
    logic       rdy0, rdy1, tx0, tx1, busy0, busy1, done0, done1;

    bit         sel;
    logic       m_tx, m_rdy, m_busy, m_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Baud tick every 4 clk, or every clk when cont_tick is set
    always @(posedge clk) div <= div + 2'd1;
    assign s_tick = cont_tick | (div == 2'd3);

    uart_tx #(.DBIT(8), .SB_TICK(16)) dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .din(din0), .tx_valid(val0),
        .tx_ready(rdy0), .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0)
    );

    uart_tx #(.DBIT(7), .SB_TICK(32)) dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .din(din1), .tx_valid(val1),
        .tx_ready(rdy1), .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1)
    );

    always_comb begin
        m_tx   = sel ? tx1   : tx0;
        m_rdy  = sel ? rdy1  : rdy0;
        m_busy = sel ? busy1 : busy0;
        m_done = sel ? done1 : done0;
    end

    typedef struct {
        bit         sel;
        logic [7:0] din;
        string      data_bits;   // data bits in line order (first sent first)
        bit         par;
        int         ticks_np;
        int         ticks_p;
        int         tp;          // clk per s_tick
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input bit s, input logic [7:0] d, input string nm);
        bit ok = 1'b0;
        sel = s;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (m_rdy === 1'b1) ok = 1'b1;
        end
        chk({nm, "_rdy_wait"}, 32'(ok), 32'd1);
        if (!ok) return;
        if (s) begin din1 = d; val1 = 1'b1; end
        else   begin din0 = d; val0 = 1'b1; end
        @(negedge clk);
        val0 = 1'b0;
        val1 = 1'b0;
        chk({nm, "_rdy_low"}, 32'(m_rdy), 32'd0);
    endtask

    // Checks one frame from its load edge (c=0) to the negedge showing tx_done_tick
    task automatic watch_frame(input string nm, input string data_bits, input bit par,
                               input int ticks, input int tp, input bit skip_wait,
                               output logic tx_at_done);
        bit         found = skip_wait;
        bit         got_done = 1'b0;
        int         tcnt;
        int         tdone = -1;
        int         nb;
        logic [11:0] seq;
        tx_at_done = 1'bx;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (m_tx === 1'b0) found = 1'b1;
        end
        chk({nm, "_start_seen"}, 32'(found), 32'd1);
        if (!found) return;
        chk({nm, "_busy"}, 32'(m_busy), 32'd1);
        seq = '0;
        seq[0] = 1'b0;
        nb = 1;
        for (int i = 0; i < data_bits.len(); i++) begin
            seq[nb] = (data_bits[i] == "1");
            nb++;
        end
`ifdef UART_TX_PARITY_EN
        seq[nb] = par;
        nb++;
`else
        if (par === 1'bx) nb = nb + 0;
`endif
        seq[nb] = 1'b1;
        nb++;
        tcnt = s_tick ? 1 : 0;
        for (int c = 1; c <= ticks * tp + 16 && !got_done; c++) begin
            @(negedge clk);
            for (int i = 0; i < nb; i++)
                if (c == 8 * tp + 16 * tp * i)
                    chk($sformatf("%s_bit%0d", nm, i), 32'(m_tx), 32'(seq[i]));
            if (m_done === 1'b1) begin
                got_done   = 1'b1;
                tdone      = tcnt;
                tx_at_done = m_tx;
            end else if (s_tick) begin
                tcnt++;
            end
        end
        chk({nm, "_done_seen"}, 32'(got_done), 32'd1);
        chk({nm, "_ticks"}, 32'(tdone), 32'(ticks));
    endtask

    task automatic idle_after(input string nm);
        @(negedge clk);
        chk({nm, "_done_1clk"}, 32'(m_done), 32'd0);
        chk({nm, "_busy_off"}, 32'(m_busy), 32'd0);
        chk({nm, "_tx_idle"}, 32'(m_tx), 32'd1);
    endtask

    function automatic int frame_ticks(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return v.ticks_p;
`else
        return v.ticks_np;
`endif
    endfunction

    initial begin
        logic txd;
        logic [7:0] hv[3];
        int k;
        bit low_ok, seen_done, seen_low;

        vecs[0] = '{1'b0, 8'hA5, "10100101", 1'b0, 160, 176, 4};
        vecs[1] = '{1'b0, 8'h07, "11100000", 1'b1, 160, 176, 4};
        vecs[2] = '{1'b0, 8'h03, "11000000", 1'b0, 160, 176, 4};
        vecs[3] = '{1'b0, 8'h00, "00000000", 1'b0, 160, 176, 4};
        vecs[4] = '{1'b0, 8'hFF, "11111111", 1'b0, 160, 176, 4};
        vecs[5] = '{1'b1, 8'hFF, "1111111",  1'b1, 160, 176, 4};
        vecs[6] = '{1'b1, 8'h80, "0000000",  1'b0, 160, 176, 4};
        vecs[7] = '{1'b1, 8'h55, "1010101",  1'b0, 160, 176, 4};
        vecs[8] = '{1'b0, 8'h3C, "00111100", 1'b0, 160, 176, 1};

        reset = 1'b1; cont_tick = 1'b0; sel = 1'b0;
        din0 = 8'h00; din1 = 8'h00; val0 = 1'b0; val1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx",    32'(tx0),   32'd1);
        chk("rst_ready", 32'(rdy0),  32'd1);
        chk("rst_busy",  32'(busy0), 32'd0);
        chk("rst_done",  32'(done0), 32'd0);
        chk("rst_tx_d7", 32'(tx1),   32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table of single frames
        foreach (vecs[i]) begin
            cont_tick = (vecs[i].tp == 1);
            send(vecs[i].sel, vecs[i].din, $sformatf("v%0d", i));
            watch_frame($sformatf("v%0d", i), vecs[i].data_bits, vecs[i].par,
                        frame_ticks(vecs[i]), vecs[i].tp, 1'b0, txd);
            idle_after($sformatf("v%0d", i));
            cont_tick = 1'b0;
        end

        // Back-to-back: 0x0F queued while 0x55 shifts
        send(1'b0, 8'h55, "b2b_a");
        fork
            watch_frame("b2b_a", "10101010", 1'b0, frame_ticks(vecs[0]), 4, 1'b0, txd);
            begin
                repeat (200) @(negedge clk);
                send(1'b0, 8'h0F, "b2b_b");
                low_ok = 1'b1;
                for (int i = 0; i < 2000 && m_done !== 1'b1; i++) begin
                    if (m_rdy !== 1'b0) low_ok = 1'b0;
                    @(negedge clk);
                end
                chk("b2b_ready_low", 32'(low_ok), 32'd1);
            end
        join
        chk("b2b_ready_back", 32'(m_rdy), 32'd1);
        chk("b2b_no_gap", 32'(txd), 32'd0);
        watch_frame("b2b_b", "11110000", 1'b0, frame_ticks(vecs[0]), 4, 1'b1, txd);
        idle_after("b2b_b");

        // tx_valid held high with garbage din while the hold is full
        hv[0] = 8'h96; hv[1] = 8'h21; hv[2] = 8'hE3;
        sel = 1'b0;
        k = 0;
        fork
            begin
                val0 = 1'b1;
                for (int i = 0; i < 3000; i++) begin
                    if (m_rdy === 1'b1) begin
                        if (k < 3) begin
                            din0 = hv[k];
                            k++;
                        end else begin
                            val0 = 1'b0;
                            break;
                        end
                    end else begin
                        din0 = 8'($urandom);
                    end
                    @(negedge clk);
                end
                val0 = 1'b0;
            end
            begin
                watch_frame("hv_a", "01101001", 1'b0, frame_ticks(vecs[0]), 4, 1'b0, txd);
                watch_frame("hv_b", "10000100", 1'b0, frame_ticks(vecs[0]), 4, 1'b1, txd);
                watch_frame("hv_c", "11000111", 1'b1, frame_ticks(vecs[0]), 4, 1'b1, txd);
            end
        join
        chk("hv_accepted", 32'(k), 32'd3);
        idle_after("hv_c");

        // Reset during data bit 3 of 0x00, with 0x81 waiting in the hold
        send(1'b0, 8'h00, "rst_a");
        seen_low = 1'b0;
        for (int i = 0; i < 100 && !seen_low; i++) begin
            @(negedge clk);
            if (m_tx === 1'b0) seen_low = 1'b1;
        end
        chk("rst_frame_start", 32'(seen_low), 32'd1);
        repeat (200) @(negedge clk);
        send(1'b0, 8'h81, "rst_q");
        repeat (86) @(negedge clk);
        chk("rst_mid_tx", 32'(m_tx), 32'd0);
        chk("rst_mid_busy", 32'(m_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_tx_hi", 32'(m_tx), 32'd1);
        chk("rst_mid_ready", 32'(m_rdy), 32'd1);
        chk("rst_mid_busy0", 32'(m_busy), 32'd0);
        seen_done = 1'b0;
        seen_low  = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (m_done !== 1'b0) seen_done = 1'b1;
            if (m_tx !== 1'b1) seen_low = 1'b1;
            @(negedge clk);
        end
        chk("rst_no_done", 32'(seen_done), 32'd0);
        chk("rst_line_quiet", 32'(seen_low), 32'd0);
        send(1'b0, 8'hC1, "rst_next");
        watch_frame("rst_next", "10000011", 1'b1, frame_ticks(vecs[0]), 4, 1'b0, txd);
        idle_after("rst_next");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
